// File: rtl/serdes_job_ctrl.sv
// Job sequencer in front of a serdes: slices one descriptor's element count into
// per-word valid counts, flags the final word, and signals done once every packed output word has left.
module serdes_job_ctrl #(
    parameter int unsigned IN_COUNT  = 10,
    parameter int unsigned OUT_COUNT = 10,
    parameter int unsigned OP_WIDTH  = 16,
    parameter int unsigned IN_WIDTH  = IN_COUNT * OP_WIDTH,
    parameter int unsigned NUM_W     = 20,
    parameter int unsigned COUNT_W   = $clog2(IN_COUNT + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [NUM_W-1:0]    cfg_num_elems,
    input  logic                src_valid,
    output logic                src_ready,
    input  logic [IN_WIDTH-1:0] src_data,
    output logic                sd_write_req,
    input  logic                sd_write_ready,
    output logic [IN_WIDTH-1:0] sd_write_data,
    output logic [COUNT_W-1:0]  sd_count,
    output logic                sd_flush,
    input  logic                sd_m_write_req,
    output logic                busy,
    output logic                done
);

    // One extra bit keeps the ceil() rounding from wrapping at the largest job size.
    localparam int unsigned EXP_W = NUM_W + 1;

    localparam logic [NUM_W-1:0]   IN_COUNT_N  = NUM_W'(IN_COUNT);
    localparam logic [COUNT_W-1:0] IN_COUNT_C  = COUNT_W'(IN_COUNT);
    localparam logic [EXP_W-1:0]   OUT_COUNT_E = EXP_W'(OUT_COUNT);
    localparam logic [EXP_W-1:0]   OUT_ROUND_E = EXP_W'(OUT_COUNT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [NUM_W-1:0] remaining;
    logic [EXP_W-1:0] expected;
    logic [EXP_W-1:0] out_cnt;

    logic [EXP_W-1:0]   expected_calc;
    logic [EXP_W-1:0]   out_cnt_inc;
    logic               last_word;
    logic [COUNT_W-1:0] word_count;
    logic               out_done;
    logic               accept;
    logic               xfer;
    logic               strobe_en;

    // Datapath decodes shared by the FSM and the registers.
    always_comb begin
        expected_calc = (EXP_W'(cfg_num_elems) + OUT_ROUND_E) / OUT_COUNT_E;
        out_cnt_inc   = out_cnt + EXP_W'(1);
        last_word     = (remaining <= IN_COUNT_N);
        word_count    = last_word ? COUNT_W'(remaining) : IN_COUNT_C;
        out_done      = (out_cnt == expected) || (sd_m_write_req && (out_cnt_inc == expected));
    end

    assign sd_write_data = src_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and handshake outputs; the write request is combinational so a word
    // moves in the cycle both sides are ready.
    always_comb begin
        state_next   = state;
        cfg_ready    = 1'b0;
        src_ready    = 1'b0;
        sd_write_req = 1'b0;
        sd_flush     = 1'b0;
        sd_count     = '0;
        accept       = 1'b0;
        xfer         = 1'b0;
        strobe_en    = 1'b0;

        unique case (state)
            ST_IDLE: begin
                cfg_ready = 1'b1;
                if (cfg_valid) begin
                    accept     = 1'b1;
                    state_next = (cfg_num_elems != '0) ? ST_ISSUE : ST_DONE;
                end
            end
            ST_ISSUE: begin
                strobe_en    = 1'b1;
                src_ready    = sd_write_ready;
                sd_write_req = src_valid && sd_write_ready;
                sd_count     = word_count;
                sd_flush     = sd_write_req && last_word;
                xfer         = sd_write_req;
                if (sd_flush) begin
                    state_next = out_done ? ST_DONE : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                strobe_en = 1'b1;
                if (out_done) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Job counters plus registered status flags that track the upcoming state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            remaining <= '0;
            expected  <= '0;
            out_cnt   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            busy <= (state_next == ST_ISSUE) || (state_next == ST_DRAIN);
            done <= (state_next == ST_DONE);

            if (accept) begin
                remaining <= cfg_num_elems;
                expected  <= expected_calc;
                out_cnt   <= '0;
            end else begin
                if (xfer) begin
                    remaining <= remaining - NUM_W'(sd_count);
                end
                if (strobe_en && sd_m_write_req && (out_cnt < expected)) begin
                    out_cnt <= out_cnt_inc;
                end
            end
        end
    end

endmodule

// File: tb/tb_serdes_job_ctrl.sv
// Directed bench for serdes_job_ctrl: hand-sequenced jobs with cycle-exact expectations.
module tb_serdes_job_ctrl;

    localparam int unsigned IN_COUNT = 10;
    localparam int unsigned OP_WIDTH = 16;
    localparam int unsigned IN_WIDTH = IN_COUNT * OP_WIDTH;
    localparam int unsigned NUM_W    = 20;
    localparam int unsigned COUNT_W  = $clog2(IN_COUNT + 1);

    logic                clk = 1'b0;
    logic                reset;
    logic                cfg_valid;
    logic                cfg_ready;
    logic [NUM_W-1:0]    cfg_num_elems;
    logic                src_valid;
    logic                src_ready;
    logic [IN_WIDTH-1:0] src_data;
    logic                sd_write_req;
    logic                sd_write_ready;
    logic [IN_WIDTH-1:0] sd_write_data;
    logic [COUNT_W-1:0]  sd_count;
    logic                sd_flush;
    logic                sd_m_write_req;
    logic                busy;
    logic                done;

    int n_vec  = 0;
    int n_miss = 0;

    serdes_job_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .cfg_valid      (cfg_valid),
        .cfg_ready      (cfg_ready),
        .cfg_num_elems  (cfg_num_elems),
        .src_valid      (src_valid),
        .src_ready      (src_ready),
        .src_data       (src_data),
        .sd_write_req   (sd_write_req),
        .sd_write_ready (sd_write_ready),
        .sd_write_data  (sd_write_data),
        .sd_count       (sd_count),
        .sd_flush       (sd_flush),
        .sd_m_write_req (sd_m_write_req),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, got running, want finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [IN_WIDTH-1:0] got, input logic [IN_WIDTH-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept_job(input logic [NUM_W-1:0] n);
        cfg_valid     = 1'b1;
        cfg_num_elems = n;
        #1;
        check("cfg_ready_at_accept", cfg_ready, 1);
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic word(input string tag, input int cnt, input logic flush);
        #1;
        check({tag, "_req"}, sd_write_req, 1);
        check({tag, "_count"}, sd_count, cnt);
        check({tag, "_flush"}, sd_flush, flush);
        tick();
    endtask

    initial begin
        reset          = 1'b1;
        cfg_valid      = 1'b0;
        cfg_num_elems  = '0;
        src_valid      = 1'b0;
        src_data       = '0;
        sd_write_ready = 1'b0;
        sd_m_write_req = 1'b0;
        #12;
        check("rst_cfg_ready", cfg_ready, 1);
        check("rst_src_ready", src_ready, 0);
        check("rst_req", sd_write_req, 0);
        check("rst_flush", sd_flush, 0);
        check("rst_count", sd_count, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        reset = 1'b0;
        tick();

        // N=25: counts 10,10,5, flush on the last, done after three output strobes.
        accept_job(20'd25);
        check("j25_busy", busy, 1);
        src_valid      = 1'b1;
        sd_write_ready = 1'b1;
        src_data       = {10{16'hA5C3}};
        #1;
        check("j25_src_ready", src_ready, 1);
        check("j25_data", sd_write_data, {10{16'hA5C3}});
        word("j25_w0", 10, 0);
        word("j25_w1", 10, 0);
        word("j25_w2", 5, 1);
        check("j25_drain_src_ready", src_ready, 0);
        check("j25_drain_req", sd_write_req, 0);
        check("j25_drain_busy", busy, 1);
        sd_m_write_req = 1'b1;
        tick();
        tick();
        check("j25_two_strobes_done", done, 0);
        tick();
        sd_m_write_req = 1'b0;
        check("j25_done", done, 1);
        check("j25_busy_low", busy, 0);
        tick();
        check("j25_done_pulse", done, 0);
        check("j25_idle_cfg_ready", cfg_ready, 1);

        // N=10: one full word flushed at once; descriptors during the job are ignored.
        accept_job(20'd10);
        cfg_valid     = 1'b1;
        cfg_num_elems = 20'd0;
        #1;
        check("j10_cfg_ready_busy", cfg_ready, 0);
        word("j10_w0", 10, 1);
        cfg_valid = 1'b0;
        check("j10_drain_busy", busy, 1);
        sd_m_write_req = 1'b1;
        tick();
        sd_m_write_req = 1'b0;
        check("j10_done", done, 1);
        tick();

        // N=25 with a 5-cycle write-ready stall after the first word.
        accept_job(20'd25);
        word("stall_w0", 10, 0);
        sd_write_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("stall_req", sd_write_req, 0);
            check("stall_src_ready", src_ready, 0);
            check("stall_count", sd_count, 10);
            tick();
        end
        sd_write_ready = 1'b1;
        word("stall_w1", 10, 0);
        word("stall_w2", 5, 1);
        sd_m_write_req = 1'b1;
        tick();
        tick();
        tick();
        sd_m_write_req = 1'b0;
        check("stall_done", done, 1);
        tick();

        // N=0: straight to done, no write traffic.
        accept_job(20'd0);
        check("j0_done", done, 1);
        check("j0_req", sd_write_req, 0);
        check("j0_busy", busy, 0);
        tick();
        check("j0_cfg_ready", cfg_ready, 1);
        check("j0_done_low", done, 0);

        // Reset in the middle of ISSUE, then a clean N=5 job.
        accept_job(20'd25);
        word("rstmid_w0", 10, 0);
        reset = 1'b1;
        #1;
        check("rstmid_cfg_ready", cfg_ready, 1);
        check("rstmid_req", sd_write_req, 0);
        check("rstmid_busy", busy, 0);
        check("rstmid_count", sd_count, 0);
        #3;
        reset = 1'b0;
        tick();
        accept_job(20'd5);
        word("j5_w0", 5, 1);
        sd_m_write_req = 1'b1;
        tick();
        sd_m_write_req = 1'b0;
        check("j5_done", done, 1);
        tick();

        // N=20: last output strobe lands with the final word, so ISSUE goes straight to DONE.
        accept_job(20'd20);
        sd_m_write_req = 1'b1;
        word("coin_w0", 10, 0);
        word("coin_w1", 10, 1);
        sd_m_write_req = 1'b0;
        check("coin_done", done, 1);
        check("coin_busy", busy, 0);
        tick();
        check("coin_done_pulse", done, 0);

        // N=30 with surplus strobes: the output count must stop at 3 for the direct exit to fire.
        accept_job(20'd30);
        sd_m_write_req = 1'b1;
        word("sat_w0", 10, 0);
        sd_write_ready = 1'b0;
        tick();
        tick();
        tick();
        sd_write_ready = 1'b1;
        word("sat_w1", 10, 0);
        word("sat_w2", 10, 1);
        sd_m_write_req = 1'b0;
        check("sat_done", done, 1);
        tick();
        check("sat_idle", cfg_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/serdes_job_ctrl.md
Name: serdes_job_ctrl

Overview:
Sequences one serdes job per descriptor. Accepts a job (total element count), forwards upstream IN_WIDTH words into the serdes write port and drives a per-word valid-element count plus flush on the final word. Monitors serdes output strobes and pulses done once all packed output words have left. Sits between the stream source (memory read / PE output) and serdes.

Parameters:
IN_COUNT, 10, operands per input word
OUT_COUNT, 10, operands per serdes output word
OP_WIDTH, 16, operand width in bits
IN_WIDTH, IN_COUNT*OP_WIDTH, input word width
NUM_W, 20, width of job element count
COUNT_W, C_LOG_2(IN_COUNT+1), width of per-word count

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
cfg_valid  in  1  job descriptor valid
cfg_ready  out  1  controller can accept descriptor
cfg_num_elems  in  NUM_W  total operands in job
src_valid  in  1  upstream word valid
src_ready  out  1  upstream word accepted when high with src_valid
src_data  in  IN_WIDTH  upstream word, operand 0 in LSBs
sd_write_req  out  1  serdes s_write_req
sd_write_ready  in  1  serdes s_write_ready
sd_write_data  out  IN_WIDTH  serdes s_write_data
sd_count  out  COUNT_W  valid operands in current word
sd_flush  out  1  serdes s_write_flush
sd_m_write_req  in  1  serdes m_write_req (output strobe, observed only)
busy  out  1  job in progress
done  out  1  one-cycle job-complete pulse

Behaviour:
- One clock; reset asynchronous, active-high. On reset: state IDLE, remaining=0, out_cnt=0, expected=0, done=0, busy=0; all combinational outputs follow IDLE values (cfg_ready=1, src_ready=0, sd_write_req=0, sd_flush=0, sd_count=0).
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE: cfg_ready=1. On cfg_valid with cfg_num_elems!=0: remaining<=N, expected<=ceil(N/OUT_COUNT), out_cnt<=0, go ISSUE. With N==0: go DONE, no serdes traffic.
- ISSUE: cfg_ready=0, busy=1. src_ready=sd_write_ready. sd_write_req=src_valid&&sd_write_ready (combinational, zero latency). sd_write_data=src_data. sd_count=min(remaining,IN_COUNT). sd_flush=sd_write_req&&(remaining<=IN_COUNT). On each transfer remaining<=remaining-sd_count. Transfer with sd_flush -> DRAIN.
- sd_write_req never asserted while sd_write_ready=0 (serdes pushes its cfg fifo on every req).
- out_cnt increments on sd_m_write_req in ISSUE, DRAIN; ignored in IDLE/DONE. Saturates at expected.
- DRAIN: busy=1, src_ready=0. When out_cnt==expected, or out_cnt==expected-1 with sd_m_write_req this cycle -> DONE.
- ISSUE exit also checks out-count: if final word transfers in the same cycle the last output strobe completes expected, go directly DONE.
- DONE: done=1 for exactly one cycle, busy=0, next IDLE. New descriptor accepted the cycle after DONE.
- Arithmetic: remaining unsigned NUM_W, never underflows (count clamped). expected computed at accept as (N+OUT_COUNT-1)/OUT_COUNT in NUM_W+1 bits to avoid overflow at N max.
- cfg_valid while not IDLE ignored (cfg_ready=0).
- Reset mid-job: immediate return to IDLE; partial serdes state is the serdes' own reset responsibility (shared reset).

Test Plan:
- N=25, src_valid always, ready always -> three sd_write_req with sd_count 10,10,5; sd_flush only on third; after 3 sd_m_write_req pulses, done one cycle, busy falls.
- N=10 -> single word, sd_count=10, sd_flush=1 same cycle; done after 1 output strobe.
- N=25, sd_write_ready low for 5 cycles mid-job -> sd_write_req and src_ready held 0; remaining unchanged; sequence resumes with correct counts.
- N=0 -> no sd_write_req; done high the cycle after accept; cfg_ready returns next cycle.
- Reset asserted in ISSUE after first word -> outputs return to reset values asynchronously; new N=5 job runs cleanly, count 5, flush on first word.
- Final output strobe coincident with last-word transfer (stubbed strobes) -> direct ISSUE->DONE, done exactly one cycle, out_cnt never exceeds expected.
